// File: rtl/firebird7_in_gate1_secure_scanmux_array_ctrl.sv
// -----------------------------------------------------------------------------
// firebird7_in_gate1_secure_scanmux_array_ctrl
//
// N-channel secure IJTAG scan-mux with an in-path control register. The
// register holds a select field (low SEL_W bits) and a key field (upper KEY_W
// bits). A new select is taken only when the key field matches KEY on update.
// A wrong key drops the mux back to channel 0, which is the safe path.
//
// Optional feature (macro SECURE_SCANMUX_LOCKOUT_EN): a saturating count of
// failed unlocks. When the count reaches MAX_FAIL the block enters LOCKOUT and
// stays there until ijtag_reset.
//
// Ports:
//   ijtag_tck    clock, rising edge
//   ijtag_reset  synchronous active-high reset
//   ijtag_sel    control register is in the active scan path
//   ijtag_ce     capture enable   (priority ce > se > ue)
//   ijtag_se     shift enable
//   ijtag_ue     update enable
//   ijtag_si     scan in
//   ijtag_so     scan out, sr[0]
//   mux_in       N_CH data chain inputs
//   mux_out      mux_in[sel_q]
//   enable_in    upstream branch enable
//   enable_out   one-hot branch enable for the selected channel
//   unlocked     state is UNLOCKED
//   sel_err      sticky: last accepted update carried an out-of-range select
// -----------------------------------------------------------------------------
module firebird7_in_gate1_secure_scanmux_array_ctrl #(
    parameter int unsigned      N_CH     = 4,
    parameter int unsigned      SEL_W    = $clog2(N_CH),
    parameter int unsigned      KEY_W    = 8,
    parameter logic [KEY_W-1:0] KEY      = 8'hA5,
    parameter int unsigned      MAX_FAIL = 3
) (
    input  logic            ijtag_tck,
    input  logic            ijtag_reset,
    input  logic            ijtag_sel,
    input  logic            ijtag_ce,
    input  logic            ijtag_se,
    input  logic            ijtag_ue,
    input  logic            ijtag_si,
    output logic            ijtag_so,
    input  logic [N_CH-1:0] mux_in,
    output logic            mux_out,
    input  logic            enable_in,
    output logic [N_CH-1:0] enable_out,
    output logic            unlocked,
    output logic            sel_err
);

    localparam int unsigned W = KEY_W + SEL_W;
    // Channel count widened by one bit so "select < N_CH" works when N_CH is a power of two.
    localparam logic [SEL_W:0] NChW = (SEL_W + 1)'(N_CH);

    // Elaboration-time guard on parameter ranges.
    if (N_CH < 2 || KEY_W < 4 || MAX_FAIL < 1) begin : g_param_err
        $error("firebird7 scanmux: N_CH >= 2, KEY_W >= 4 and MAX_FAIL >= 1 required");
    end

    typedef enum logic [1:0] {
        StLocked   = 2'd0,
        StUnlocked = 2'd1,
        StLockout  = 2'd2
    } state_e;

    state_e           state_q;
    logic [W-1:0]     sr_q;
    logic [SEL_W-1:0] sel_q;
    logic             sel_err_q;

    logic [SEL_W-1:0] sel_field;
    logic [KEY_W-1:0] key_field;
    logic [KEY_W-1:0] key_cap;
    logic             key_match;
    logic             sel_in_range;
    logic             lockout;

    assign sel_field    = sr_q[SEL_W-1:0];
    assign key_field    = sr_q[W-1:SEL_W];
    assign key_match    = (key_field == KEY);
    assign sel_in_range = ({1'b0, sel_field} < NChW);
    assign lockout      = (state_q == StLockout);

    // Status word loaded into the key field on capture; the key itself never reads back.
    always_comb begin
        key_cap    = '0;
        key_cap[0] = (state_q == StUnlocked);
        key_cap[1] = sel_err_q;
        key_cap[2] = lockout;
    end

`ifdef SECURE_SCANMUX_LOCKOUT_EN
    localparam int unsigned    CNT_W       = $clog2(MAX_FAIL + 1);
    localparam logic [CNT_W-1:0] MaxFailCnt = CNT_W'(MAX_FAIL);
    localparam logic [CNT_W-1:0] LastTry    = CNT_W'(MAX_FAIL - 1);

    logic [CNT_W-1:0] fail_cnt_q;
`endif

    always_ff @(posedge ijtag_tck) begin
        if (ijtag_reset) begin
            state_q    <= StLocked;
            sr_q       <= '0;
            sel_q      <= '0;
            sel_err_q  <= 1'b0;
`ifdef SECURE_SCANMUX_LOCKOUT_EN
            fail_cnt_q <= '0;
`endif
        end else if (ijtag_sel) begin
            if (ijtag_ce) begin
                sr_q <= {key_cap, sel_q};
            end else if (ijtag_se) begin
                sr_q <= {ijtag_si, sr_q[W-1:1]};
            end else if (ijtag_ue) begin
`ifdef SECURE_SCANMUX_LOCKOUT_EN
                if (!lockout) begin
                    if (key_match) begin
                        fail_cnt_q <= '0;
                        state_q    <= StUnlocked;
                        if (sel_in_range) begin
                            sel_q     <= sel_field;
                            sel_err_q <= 1'b0;
                        end else begin
                            sel_err_q <= 1'b1;
                        end
                    end else if (fail_cnt_q >= LastTry) begin
                        fail_cnt_q <= MaxFailCnt;
                        state_q    <= StLockout;
                        sel_q      <= '0;
                    end else begin
                        fail_cnt_q <= fail_cnt_q + 1'b1;
                        state_q    <= StLocked;
                        sel_q      <= '0;
                    end
                end
`else
                if (key_match) begin
                    state_q <= StUnlocked;
                    if (sel_in_range) begin
                        sel_q     <= sel_field;
                        sel_err_q <= 1'b0;
                    end else begin
                        sel_err_q <= 1'b1;
                    end
                end else begin
                    state_q <= StLocked;
                    sel_q   <= '0;
                end
`endif
            end
        end
    end

    assign ijtag_so = sr_q[0];
    assign unlocked = (state_q == StUnlocked);
    assign sel_err  = sel_err_q;

    // sel_q never leaves [0, N_CH), so the decode is one-hot or zero.
    always_comb begin
        mux_out    = 1'b0;
        enable_out = '0;
        for (int i = 0; i < int'(N_CH); i++) begin
            if (sel_q == SEL_W'(i)) begin
                mux_out       = mux_in[i];
                enable_out[i] = enable_in;
            end
        end
    end

endmodule

// File: tb/tb_firebird7_in_gate1_secure_scanmux_array_ctrl.sv
// Directed bench: a 4-channel and a 3-channel instance share all scan
// controls, so one stimulus sequence exercises both select ranges.
module tb_firebird7_in_gate1_secure_scanmux_array_ctrl;

    logic       ijtag_tck = 1'b0;
    logic       ijtag_reset = 1'b1;
    logic       ijtag_sel = 1'b0;
    logic       ijtag_ce = 1'b0;
    logic       ijtag_se = 1'b0;
    logic       ijtag_ue = 1'b0;
    logic       ijtag_si = 1'b0;
    logic       enable_in = 1'b1;
    logic [3:0] mux_in4 = 4'b0001;
    logic [2:0] mux_in3 = 3'b001;

    logic       so4, so3, mux_out4, mux_out3, unl4, unl3, serr4, serr3;
    logic [3:0] en4;
    logic [2:0] en3;

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    logic [9:0] w4, w3;

    always #5 ijtag_tck = ~ijtag_tck;

    firebird7_in_gate1_secure_scanmux_array_ctrl #(.N_CH(4)) u_dut4 (
        .ijtag_tck  (ijtag_tck),
        .ijtag_reset(ijtag_reset),
        .ijtag_sel  (ijtag_sel),
        .ijtag_ce   (ijtag_ce),
        .ijtag_se   (ijtag_se),
        .ijtag_ue   (ijtag_ue),
        .ijtag_si   (ijtag_si),
        .ijtag_so   (so4),
        .mux_in     (mux_in4),
        .mux_out    (mux_out4),
        .enable_in  (enable_in),
        .enable_out (en4),
        .unlocked   (unl4),
        .sel_err    (serr4)
    );

    firebird7_in_gate1_secure_scanmux_array_ctrl #(.N_CH(3)) u_dut3 (
        .ijtag_tck  (ijtag_tck),
        .ijtag_reset(ijtag_reset),
        .ijtag_sel  (ijtag_sel),
        .ijtag_ce   (ijtag_ce),
        .ijtag_se   (ijtag_se),
        .ijtag_ue   (ijtag_ue),
        .ijtag_si   (ijtag_si),
        .ijtag_so   (so3),
        .mux_in     (mux_in3),
        .mux_out    (mux_out3),
        .enable_in  (enable_in),
        .enable_out (en3),
        .unlocked   (unl3),
        .sel_err    (serr3)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge ijtag_tck);
        #1;
    endtask

    task automatic shift_in(input logic [9:0] w);
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            ijtag_si = w[i];
            tick();
        end
        ijtag_se = 1'b0;
        ijtag_si = 1'b0;
    endtask

    task automatic update();
        ijtag_sel = 1'b1;
        ijtag_ue  = 1'b1;
        tick();
        ijtag_ue  = 1'b0;
    endtask

    task automatic capture();
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b1;
        tick();
        ijtag_ce  = 1'b0;
    endtask

    // Reads sr LSB first; zeros are shifted in behind.
    task automatic shift_out(output logic [9:0] o4, output logic [9:0] o3);
        ijtag_sel = 1'b1;
        ijtag_se  = 1'b1;
        ijtag_si  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            o4[i] = so4;
            o3[i] = so3;
            tick();
        end
        ijtag_se = 1'b0;
    endtask

    initial begin
        // Reset for two cycles.
        tick();
        tick();
        ijtag_reset = 1'b0;
        check("rst_unlocked4", {31'd0, unl4}, 32'd0);
        check("rst_so4", {31'd0, so4}, 32'd0);
        check("rst_en4", {28'd0, en4}, 32'h1);
        check("rst_en3", {29'd0, en3}, 32'h1);
        check("rst_mux4", {31'd0, mux_out4}, 32'd1);
        check("rst_selerr4", {31'd0, serr4}, 32'd0);

        // Unlock to channel 2.
        shift_in(10'h296);
        check("pre_upd_en4", {28'd0, en4}, 32'h1);
        update();
        check("unl_unlocked4", {31'd0, unl4}, 32'd1);
        check("unl_en4", {28'd0, en4}, 32'h4);
        check("unl_en3", {29'd0, en3}, 32'h4);
        mux_in4 = 4'b0100;
        #1;
        check("unl_mux4_hi", {31'd0, mux_out4}, 32'd1);
        mux_in4 = 4'b1011;
        #1;
        check("unl_mux4_lo", {31'd0, mux_out4}, 32'd0);

        // Wrong key relocks to channel 0.
        shift_in(10'h003);
        update();
        check("relock_unlocked4", {31'd0, unl4}, 32'd0);
        check("relock_en4", {28'd0, en4}, 32'h1);
        check("relock_en3", {29'd0, en3}, 32'h1);
        capture();
        shift_out(w4, w3);
        check("relock_cap4", {22'd0, w4}, 32'h000);
        check("relock_cap3", {22'd0, w3}, 32'h000);

        // Select 1, then select 3: in range for 4 channels, out of range for 3.
        shift_in(10'h295);
        update();
        check("sel1_en3", {29'd0, en3}, 32'h2);
        shift_in(10'h297);
        update();
        check("oor_en3", {29'd0, en3}, 32'h2);
        check("oor_selerr3", {31'd0, serr3}, 32'd1);
        check("oor_unlocked3", {31'd0, unl3}, 32'd1);
        check("sel3_en4", {28'd0, en4}, 32'h8);
        check("sel3_selerr4", {31'd0, serr4}, 32'd0);
        capture();
        shift_out(w4, w3);
        check("oor_cap3", {22'd0, w3}, 32'h00D);
        check("sel3_cap4", {22'd0, w4}, 32'h007);

        // ijtag_sel=0 blocks shift and update.
        shift_in(10'h0F1);
        ijtag_sel = 1'b0;
        ijtag_se  = 1'b1;
        ijtag_ue  = 1'b1;
        ijtag_si  = 1'b1;
        for (int i = 0; i < 10; i++) tick();
        ijtag_se = 1'b0;
        ijtag_ue = 1'b0;
        ijtag_si = 1'b0;
        check("nosel_unlocked4", {31'd0, unl4}, 32'd1);
        check("nosel_en4", {28'd0, en4}, 32'h8);
        check("nosel_en3", {29'd0, en3}, 32'h2);
        shift_out(w4, w3);
        check("nosel_sr4", {22'd0, w4}, 32'h0F1);
        check("nosel_sr3", {22'd0, w3}, 32'h0F1);

        // ce+se+ue together: only capture acts (sr holds a wrong key, so ue would relock).
        ijtag_sel = 1'b1;
        ijtag_ce  = 1'b1;
        ijtag_se  = 1'b1;
        ijtag_ue  = 1'b1;
        ijtag_si  = 1'b1;
        tick();
        ijtag_ce = 1'b0;
        ijtag_se = 1'b0;
        ijtag_ue = 1'b0;
        ijtag_si = 1'b0;
        check("prio_unlocked4", {31'd0, unl4}, 32'd1);
        check("prio_en4", {28'd0, en4}, 32'h8);
        shift_out(w4, w3);
        check("prio_cap4", {22'd0, w4}, 32'h007);
        check("prio_cap3", {22'd0, w3}, 32'h00D);

        // Three wrong keys then a correct one.
        for (int i = 0; i < 3; i++) begin
            shift_in(10'h169);
            update();
        end
        shift_in(10'h296);
        update();
`ifdef SECURE_SCANMUX_LOCKOUT_EN
        check("lko_unlocked4", {31'd0, unl4}, 32'd0);
        check("lko_en4", {28'd0, en4}, 32'h1);
        check("lko_en3", {29'd0, en3}, 32'h1);
        capture();
        shift_out(w4, w3);
        check("lko_cap4", {22'd0, w4}, 32'h010);
        check("lko_cap3", {22'd0, w3}, 32'h018);
`else
        check("4th_unlocked4", {31'd0, unl4}, 32'd1);
        check("4th_en4", {28'd0, en4}, 32'h4);
        check("4th_en3", {29'd0, en3}, 32'h4);
        capture();
        shift_out(w4, w3);
        check("4th_cap4", {22'd0, w4}, 32'h006);
        check("4th_cap3", {22'd0, w3}, 32'h006);
`endif

        // Load ones, then reset while shifting.
        shift_in(10'h3FF);
        ijtag_se    = 1'b1;
        ijtag_si    = 1'b1;
        ijtag_reset = 1'b1;
        tick();
        ijtag_reset = 1'b0;
        ijtag_se    = 1'b0;
        ijtag_si    = 1'b0;
        check("midrst_so4", {31'd0, so4}, 32'd0);
        check("midrst_unlocked4", {31'd0, unl4}, 32'd0);
        check("midrst_en4", {28'd0, en4}, 32'h1);
        check("midrst_selerr3", {31'd0, serr3}, 32'd0);

        // Correct key unlocks after reset.
        shift_in(10'h297);
        update();
        check("post_unlocked4", {31'd0, unl4}, 32'd1);
        check("post_en4", {28'd0, en4}, 32'h8);
        check("post_en3", {29'd0, en3}, 32'h1);
        check("post_selerr3", {31'd0, serr3}, 32'd1);
        check("post_mux3", {31'd0, mux_out3}, 32'd1);
        enable_in = 1'b0;
        #1;
        check("noen_en4", {28'd0, en4}, 32'h0);
        check("noen_en3", {29'd0, en3}, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
